// File: rtl/spi_byte_rx.sv
// SPI (mode 0) slave receiver. It synchronises sclk, ss_n and mosi into clk,
// assembles MSB-first frames and buffers them in a first-word-fall-through FIFO.
`timescale 1ns/1ps
module spi_byte_rx #(
    parameter int DATA_W      = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            sclk,
    input  logic                            ss_n,
    input  logic                            mosi,
    output logic [DATA_W-1:0]               dout,
    output logic                            dout_valid,
    input  logic                            dout_ready,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic                            overflow,
    output logic                            frame_err
);

    localparam int CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic {IDLE, RECV} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_reg;
    logic [SYNC_STAGES-1:0] ss_n_sync_reg;
    logic [SYNC_STAGES-1:0] mosi_sync_reg;

    // Each stage resets to the line's idle level so no false edge follows reset.
    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        sclk_sync_reg[gi] <= 1'b0;
                        ss_n_sync_reg[gi] <= 1'b1;
                        mosi_sync_reg[gi] <= 1'b0;
                    end else begin
                        sclk_sync_reg[gi] <= sclk;
                        ss_n_sync_reg[gi] <= ss_n;
                        mosi_sync_reg[gi] <= mosi;
                    end
                end
            end else begin : g_next
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        sclk_sync_reg[gi] <= 1'b0;
                        ss_n_sync_reg[gi] <= 1'b1;
                        mosi_sync_reg[gi] <= 1'b0;
                    end else begin
                        sclk_sync_reg[gi] <= sclk_sync_reg[gi-1];
                        ss_n_sync_reg[gi] <= ss_n_sync_reg[gi-1];
                        mosi_sync_reg[gi] <= mosi_sync_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    logic sclk_s, ss_n_s, mosi_s;
    assign sclk_s = sclk_sync_reg[SYNC_STAGES-1];
    assign ss_n_s = ss_n_sync_reg[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_reg[SYNC_STAGES-1];

    state_t             state_reg;
    logic [CNT_W-1:0]   bit_cnt_reg;
    logic [DATA_W-2:0]  shift_reg;
    logic               sclk_prev_reg;
    logic               frame_err_reg;

    logic               sclk_rise;
    logic               last_bit;
    logic               push;
    logic [DATA_W-1:0]  shift_next;

    assign sclk_rise  = sclk_s & ~sclk_prev_reg;
    assign last_bit   = (bit_cnt_reg == CNT_W'(DATA_W - 1));
    assign shift_next = {shift_reg, mosi_s};
    // The final bit goes straight into the FIFO word; the shift register holds only DATA_W-1 bits.
    assign push       = (state_reg == RECV) && !ss_n_s && sclk_rise && last_bit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            sclk_prev_reg <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            sclk_prev_reg <= sclk_s;
            frame_err_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    bit_cnt_reg <= '0;
                    shift_reg   <= '0;
                    if (!ss_n_s)
                        state_reg <= RECV;
                end
                RECV: begin
                    if (ss_n_s) begin
                        state_reg     <= IDLE;
                        bit_cnt_reg   <= '0;
                        shift_reg     <= '0;
                        frame_err_reg <= (bit_cnt_reg != '0);
                    end else if (sclk_rise) begin
                        shift_reg   <= shift_next[DATA_W-2:0];
                        bit_cnt_reg <= last_bit ? '0 : bit_cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign frame_err = frame_err_reg;

    logic [DATA_W-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [FCNT_W-1:0]  count_reg;
    logic               overflow_reg;
    logic               full;
    logic               pop;
    logic               wr_en;

    assign full       = (count_reg == FCNT_W'(FIFO_DEPTH));
    assign dout_valid = (count_reg != '0);
    assign pop        = dout_valid & dout_ready;
    assign wr_en      = push & (~full | pop);

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr_reg] <= shift_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (wr_en)
                wr_ptr_reg <= (wr_ptr_reg == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= (rd_ptr_reg == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
            case ({wr_en, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            if (push && full && !pop)
                overflow_reg <= 1'b1;
        end
    end

    assign fifo_count = count_reg;
    assign overflow   = overflow_reg;
    assign dout       = dout_valid ? mem[rd_ptr_reg] : '0;

endmodule

// File: doc/spi_byte_rx.md
SPI_BYTE_RX -- requirements
Module: spi_byte_rx

Interface
REQ-001 SHALL have parameter DATA_W, default 8, giving the SPI frame width in bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, giving the receive buffer depth (power of two).
REQ-003 SHALL have parameter SYNC_STAGES, default 2, giving the number of synchronizer flops on sclk, ss_n and mosi.
REQ-004 clk  input  1  system clock; the block has one clock, and all logic runs on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 sclk  input  1  SPI serial clock from the master; asynchronous to clk; CPOL=0, CPHA=0.
REQ-007 ss_n  input  1  SPI slave select, active-low, asynchronous.
REQ-008 mosi  input  1  SPI serial data, MSB first, asynchronous.
REQ-009 dout  output  DATA_W  received byte at the FIFO head.
REQ-010 dout_valid  output  1  dout holds a valid byte.
REQ-011 dout_ready  input  1  consumer accepts dout when dout_valid is also high.
REQ-012 fifo_count  output  $clog2(FIFO_DEPTH)+1  number of bytes held in the FIFO.
REQ-013 overflow  output  1  sticky flag: a received byte was dropped because the FIFO was full.
REQ-014 frame_err  output  1  one-cycle pulse: ss_n deasserted mid-byte.

Function
REQ-015 sclk, ss_n and mosi SHALL each pass through SYNC_STAGES flops; all decisions SHALL use the synchronized values only.
REQ-016 An sclk rising edge SHALL be detected as synchronized sclk=1 while its previous registered value=0; clk frequency is at least 4x sclk frequency.
REQ-017 The FSM SHALL have two states, IDLE and RECV.
REQ-018 IDLE->RECV SHALL occur when synchronized ss_n=0; bit counter=0 and shift register=0 on entry.
REQ-019 RECV->IDLE SHALL occur when synchronized ss_n=1.
REQ-020 In RECV, each detected sclk rising edge SHALL shift synchronized mosi into the shift register LSB and increment the bit counter.
REQ-021 On the DATA_W-th sample, the composed byte {shift[DATA_W-2:0], mosi} SHALL be pushed into the FIFO on that same clk edge, and the bit counter SHALL wrap to 0.
REQ-022 Multiple back-to-back bytes within one ss_n assertion SHALL each be pushed.
REQ-023 If ss_n deasserts while bit counter is 1..DATA_W-1, the partial byte SHALL be discarded and frame_err SHALL pulse high for exactly one clk.
REQ-024 If ss_n deasserts while bit counter is 0, frame_err SHALL NOT pulse.
REQ-025 sclk edges in IDLE SHALL be ignored.
REQ-026 Latency: dout_valid SHALL rise exactly SYNC_STAGES+1 clk edges after the first clk edge that samples sclk high at the pin for the last bit, provided the FIFO was empty.
REQ-027 The FIFO SHALL be first-word-fall-through: dout = head entry whenever fifo_count>0.
REQ-028 dout_valid SHALL equal (fifo_count != 0).
REQ-029 dout SHALL stay stable while dout_valid=1 and dout_ready=0.
REQ-030 A pop SHALL occur when dout_valid=1 and dout_ready=1; dout_ready with an empty FIFO SHALL have no effect.
REQ-031 A push with the FIFO full and no simultaneous pop SHALL drop the byte, leave the FIFO unchanged, and set overflow=1.
REQ-032 A push and a pop in the same cycle when full SHALL both be accepted, with fifo_count unchanged and no overflow.
REQ-033 A push and a pop in the same cycle when empty is impossible; the pushed byte SHALL appear on the next cycle.
REQ-034 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH; fifo_count SHALL saturate at FIFO_DEPTH and never go below 0.
REQ-035 overflow SHALL clear only on rst.

Reset
REQ-036 rst=1 SHALL immediately force: FSM=IDLE, bit counter=0, shift register=0, FIFO pointers=0, fifo_count=0, dout_valid=0, dout=0, overflow=0, frame_err=0, synchronizer flops to idle levels (sclk=0, ss_n=1, mosi=0).
REQ-037 Reset mid-byte SHALL discard the partial byte and all FIFO contents; the first frame after rst release SHALL be received correctly from its first bit.

Verification
REQ-038 Reset check: assert rst with sclk toggling -> dout=0, dout_valid=0, fifo_count=0, overflow=0, frame_err=0 throughout.
REQ-039 Single byte: send 0xA5 with dout_ready=0 -> dout=0xA5 and dout_valid=1 exactly 3 clks after the last sclk edge is sampled, fifo_count=1; then pulse dout_ready -> fifo_count=0, dout_valid=0.
REQ-040 Multi-byte frame: one ss_n assertion carrying 0x3C, 0x0F, 0xFF with dout_ready=1 -> three pops in order 0x3C, 0x0F, 0xFF; frame_err stays 0.
REQ-041 Aborted byte: 5 bits, then ss_n high -> frame_err high for 1 clk, fifo_count unchanged; a following frame 0x81 -> dout=0x81.
REQ-042 Overflow: 5 bytes 0x01..0x05 sent with dout_ready=0 -> fifo_count=4, overflow=1; draining yields 0x01..0x04. Also push and pop in the same cycle at full -> no overflow.
REQ-043 Mid-byte reset: rst pulse after 4 bits of 0xF0, then send 0x5A -> only 0x5A received, overflow=0.
